// File: rtl/audio_tone_seq.sv
// audio_tone_seq: multi-channel square-wave tone player.
// Latches N_CH half-period words on bandera and plays them on a 1-bit audio
// output, either one channel after another (one-shot or loop) or all channels
// at once XOR-mixed.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   bandera      load/start strobe
//   in_bus       packed half-periods, channel i = in_bus[i*W +: W]
//   modo         0 one-shot, 1 loop, 2 XOR mix, 3 same as 0
//   salida_audio registered square-wave output
//   ocupado      high while playing
//   canal_act    channel currently sounding (0 in mix mode)
//   fin          one-cycle pulse at the end of a one-shot sequence
module audio_tone_seq #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned W       = 29,
  parameter int unsigned SEG_LEN = 2100000,
  parameter int unsigned SEG_W   = 22,
  localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bandera,
  input  logic [N_CH*W-1:0] in_bus,
  input  logic [1:0]        modo,
  output logic              salida_audio,
  output logic              ocupado,
  output logic [CW-1:0]     canal_act,
  output logic              fin
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      hp_q  [N_CH];
  logic [W-1:0]      hp_d  [N_CH];
  logic [W-1:0]      cnt_q [N_CH];
  logic [W-1:0]      cnt_d [N_CH];
  logic [N_CH-1:0]   ph_q, ph_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     ch_d;
  logic              salida_d, ocupado_d, fin_d;
  logic              done_c;
  logic              mix_c, loop_c;

  assign mix_c  = (mode_q == 2'd2);
  assign loop_c = (mode_q == 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: strobe always (re)starts, end of one-shot returns to idle
  always_comb begin
    state_d = state_q;
    if (bandera)     state_d = PLAY;
    else if (done_c) state_d = IDLE;
  end

  // Datapath and output next values
  always_comb begin
    hp_d      = hp_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    seg_d     = seg_q;
    mode_d    = mode_q;
    ch_d      = canal_act;
    salida_d  = salida_audio;
    ocupado_d = ocupado;
    fin_d     = 1'b0;
    done_c    = 1'b0;

    if (bandera) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hp_d[i]  = in_bus[i*W +: W];
        cnt_d[i] = '0;
      end
      ph_d      = '0;
      seg_d     = '0;
      mode_d    = modo;
      ch_d      = '0;
      salida_d  = 1'b0;
      ocupado_d = 1'b1;
    end else if (state_q == PLAY) begin
      // Tone generators: only the active channel runs in sequential modes
      for (int i = 0; i < int'(N_CH); i++) begin
        if (mix_c || (canal_act == CW'(i))) begin
          if (hp_q[i] == '0) begin
            cnt_d[i] = '0;
            ph_d[i]  = 1'b0;
          end else if (cnt_q[i] == hp_q[i] - W'(1)) begin
            cnt_d[i] = '0;
            ph_d[i]  = ~ph_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + W'(1);
          end
        end
      end

      if (mix_c) begin
        seg_d    = '0;
        ch_d     = '0;
        salida_d = ^ph_d;
      end else begin
        seg_d = seg_q + SEG_W'(1);
        // Segment end overrides any coincident toggle of the active channel
        if (seg_q == SEG_W'(SEG_LEN - 1)) begin
          seg_d = '0;
          for (int i = 0; i < int'(N_CH); i++) begin
            if (canal_act == CW'(i)) begin
              cnt_d[i] = '0;
              ph_d[i]  = 1'b0;
            end
          end
          if (canal_act != CW'(N_CH - 1)) ch_d = canal_act + CW'(1);
          else if (loop_c)                ch_d = '0;
          else                            done_c = 1'b1;
        end
        salida_d = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
          if (ch_d == CW'(i)) salida_d = ph_d[i];
        end
        if (done_c) begin
          salida_d  = 1'b0;
          ocupado_d = 1'b0;
          fin_d     = 1'b1;
        end
      end
    end else begin
      salida_d  = 1'b0;
      ocupado_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ph_q         <= '0;
      seg_q        <= '0;
      mode_q       <= '0;
      canal_act    <= '0;
      salida_audio <= 1'b0;
      ocupado      <= 1'b0;
      fin          <= 1'b0;
    end else begin
      hp_q         <= hp_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      seg_q        <= seg_d;
      mode_q       <= mode_d;
      canal_act    <= ch_d;
      salida_audio <= salida_d;
      ocupado      <= ocupado_d;
      fin          <= fin_d;
    end
  end

endmodule

// File: tb/tb_audio_tone_seq.sv
// Bench for audio_tone_seq: table vectors, hand sequences for restart/reset,
// and a randomized run against a time-since-load reference model.
module tb_audio_tone_seq;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned W       = 8;
  localparam int unsigned SEG_LEN = 100;
  localparam int unsigned SEG_W   = 7;

  logic              clk;
  logic              rst;
  logic              bandera;
  logic [N_CH*W-1:0] in_bus;
  logic [1:0]        modo;
  logic              salida_audio;
  logic              ocupado;
  logic [1:0]        canal_act;
  logic              fin;

  int checks   = 0;
  int failures = 0;

  audio_tone_seq #(
    .N_CH(N_CH), .W(W), .SEG_LEN(SEG_LEN), .SEG_W(SEG_W)
  ) dut (
    .clk(clk), .rst(rst), .bandera(bandera), .in_bus(in_bus), .modo(modo),
    .salida_audio(salida_audio), .ocupado(ocupado), .canal_act(canal_act), .fin(fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h0, h1, h2, md, t;
    int sal, can, chk_can, oc, fn;
  } vec_t;

  vec_t tbl[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int sal, input int can,
                           input int chk_can, input int oc, input int fn);
    check({name, ".salida"}, int'(salida_audio), sal);
    if (chk_can != 0) check({name, ".canal"}, int'(canal_act), can);
    check({name, ".ocupado"}, int'(ocupado), oc);
    check({name, ".fin"}, int'(fin), fn);
  endtask

  function automatic logic [N_CH*W-1:0] pack(input int h0, input int h1, input int h2);
    logic [W-1:0] a, b, c;
    a = W'(h0); b = W'(h1); c = W'(h2);
    return {c, b, a};
  endfunction

  // Expected outputs t edges after a load, derived from segment arithmetic
  function automatic void model(input int hp[3], input int md, input int t,
                                output int sal, output int can, output int chk,
                                output int oc, output int fn);
    int m, c, p, ch, x;
    m = (md == 3) ? 0 : md;
    sal = 0; can = 0; chk = 1; oc = 1; fn = 0;
    if (t == 0) return;
    if (m == 2) begin
      x = 0;
      for (int i = 0; i < 3; i++) if (hp[i] != 0) x ^= (t / hp[i]) % 2;
      sal = x;
      return;
    end
    c = (t - 1) / int'(SEG_LEN);
    p = t - c * int'(SEG_LEN);
    if (m == 0 && c >= int'(N_CH)) begin
      oc = 0; chk = 0;
    end else if (p == int'(SEG_LEN)) begin
      if (m == 0 && c == int'(N_CH) - 1) begin
        oc = 0; fn = 1; chk = 0;
      end else begin
        can = (c + 1) % int'(N_CH);
      end
    end else begin
      ch  = c % int'(N_CH);
      can = ch;
      sal = (hp[ch] != 0) ? (t - c * int'(SEG_LEN)) / hp[ch] % 2 : 0;
    end
  endfunction

  task automatic load(input int h0, input int h1, input int h2, input int md);
    in_bus  = pack(h0, h1, h2);
    modo    = 2'(md);
    bandera = 1'b1;
    step();
    bandera = 1'b0;
  endtask

  initial begin
    int hp[3];
    int t, md, s, cn, ck, oc, fn;
    logic loaded;

    tbl[0]  = '{11, 4, 9, 0,   0, 0, 0, 1, 1, 0};
    tbl[1]  = '{11, 4, 9, 0,  10, 0, 0, 1, 1, 0};
    tbl[2]  = '{11, 4, 9, 0,  11, 1, 0, 1, 1, 0};
    tbl[3]  = '{11, 4, 9, 0,  22, 0, 0, 1, 1, 0};
    tbl[4]  = '{11, 4, 9, 0, 100, 0, 1, 1, 1, 0};
    tbl[5]  = '{11, 4, 9, 0, 104, 1, 1, 1, 1, 0};
    tbl[6]  = '{11, 4, 9, 0, 200, 0, 2, 1, 1, 0};
    tbl[7]  = '{11, 4, 9, 0, 209, 1, 2, 1, 1, 0};
    tbl[8]  = '{11, 4, 9, 0, 299, 1, 2, 1, 1, 0};
    tbl[9]  = '{11, 4, 9, 0, 300, 0, 0, 0, 0, 1};
    tbl[10] = '{11, 4, 9, 0, 301, 0, 0, 0, 0, 0};
    tbl[11] = '{11, 0, 9, 0, 150, 0, 1, 1, 1, 0};
    tbl[12] = '{11, 0, 9, 0, 199, 0, 1, 1, 1, 0};
    tbl[13] = '{11, 4, 9, 1, 300, 0, 0, 1, 1, 0};
    tbl[14] = '{11, 4, 9, 1, 311, 1, 0, 1, 1, 0};
    tbl[15] = '{ 2, 3, 0, 2,   5, 1, 0, 1, 1, 0};
    tbl[16] = '{ 2, 3, 0, 2,  12, 0, 0, 1, 1, 0};
    tbl[17] = '{ 2, 3, 0, 2,   2, 1, 0, 1, 1, 0};
    tbl[18] = '{11, 4, 9, 3, 300, 0, 0, 0, 0, 1};
    tbl[19] = '{ 1, 4, 9, 0,   1, 1, 0, 1, 1, 0};

    rst = 1'b1; bandera = 1'b0; in_bus = '0; modo = 2'd0;
    step(); step();
    check_all("reset", 0, 0, 1, 0, 0);
    rst = 1'b0;
    step();
    check_all("idle_after_reset", 0, 0, 1, 0, 0);

    // Table vectors: load, advance t edges, compare
    foreach (tbl[v]) begin
      load(tbl[v].h0, tbl[v].h1, tbl[v].h2, tbl[v].md);
      for (int i = 0; i < tbl[v].t; i++) step();
      check_all($sformatf("vec%0d", v), tbl[v].sal, tbl[v].can,
                tbl[v].chk_can, tbl[v].oc, tbl[v].fn);
    end

    // Restart mid channel 1
    load(11, 4, 9, 0);
    for (int i = 0; i < 150; i++) step();
    check("restart.pre_canal", int'(canal_act), 1);
    load(32, 3, 9, 0);
    check_all("restart.t0", 0, 0, 1, 1, 0);
    for (int i = 0; i < 31; i++) step();
    check("restart.t31", int'(salida_audio), 0);
    step();
    check("restart.t32", int'(salida_audio), 1);
    for (int i = 0; i < 68; i++) step();
    check_all("restart.t100", 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step();
    check("restart.t103", int'(salida_audio), 1);

    // Reset during play
    load(11, 4, 9, 0);
    for (int i = 0; i < 50; i++) step();
    rst = 1'b1;
    step();
    check_all("rst_mid", 0, 0, 1, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check_all("rst_mid.idle", 0, 0, 1, 0, 0);

    // Long mix run: never ends, follows XOR of the two tones
    hp = '{2, 3, 0};
    load(2, 3, 0, 2);
    for (int i = 1; i <= 1000; i++) begin
      step();
      model(hp, 2, i, s, cn, ck, oc, fn);
      check("mix_long.fin", int'(fin), 0);
      check("mix_long.salida", int'(salida_audio), s);
    end

    // Randomized: inputs wiggle every cycle, only strobed values count
    loaded = 1'b0; t = 0; md = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r0, r1, r2, rm;
      logic b;
      r0 = $urandom_range(0, 40);
      r1 = $urandom_range(0, 40);
      r2 = $urandom_range(0, 40);
      rm = $urandom_range(0, 3);
      b  = (cyc == 0) || ($urandom_range(0, 249) == 0);
      in_bus  = pack(r0, r1, r2);
      modo    = 2'(rm);
      bandera = b;
      step();
      if (b) begin
        hp = '{r0, r1, r2}; md = rm; t = 0; loaded = 1'b1;
      end else begin
        t++;
      end
      if (loaded) begin
        model(hp, md, t, s, cn, ck, oc, fn);
        check_all("rnd", s, cn, ck, oc, fn);
      end
    end
    bandera = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_tone_seq.md
Name: audio_tone_seq

Overview:
- Parametrised successor of the three-tone audio output stage.
- Latches N_CH half-period words on the bandera strobe and plays them as 1-bit square-wave tones on salida_audio.
- Play modes: sequential one-shot, sequential loop, or simultaneous XOR mix.
- Sits between the register and alarm logic that produces the tone words and the audio pin.

Parameters:
- N_CH, 3, number of tone channels (>=2).
- W, 29, width of each half-period word, in clk cycles.
- SEG_LEN, 2100000, segment length per channel in sequential modes, in clk cycles (>=2).
- SEG_W, 22, segment counter width; must hold SEG_LEN-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- bandera  input  1  load/start strobe, sampled at each clk edge.
- in_bus  input  N_CH*W  packed half-periods; channel i = in_bus[i*W +: W].
- modo  input  2  play mode: 0 = sequential one-shot, 1 = sequential loop, 2 = XOR mix, 3 = treated as 0.
- salida_audio  output  1  registered square-wave audio.
- ocupado  output  1  high while playing.
- canal_act  output  max(1,clog2(N_CH))  channel currently sounding (sequential modes), 0 in mix mode.
- fin  output  1  one-cycle pulse at the end of a one-shot sequence.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst is synchronous and active-high.
  - rst has priority over everything: state=IDLE; all shadow, counter and phase registers = 0; salida_audio=0, ocupado=0, canal_act=0, fin=0.
- States: IDLE, PLAY.
- Load (bandera=1 at edge k, in any state):
  - Latch in_bus into shadow registers hp[i] and modo into mode_r.
  - Clear all tone counters cnt[i], phases ph[i] and seg; canal_act=0.
  - state=PLAY, ocupado=1, fin=0.
  - Mid-play bandera is an immediate restart. in_bus and modo are ignored at all other times.
- Tone generator (per channel i, on each PLAY edge where the channel runs):
  - hp[i]==0: cnt[i] and ph[i] held at 0 (silence).
  - Otherwise, if cnt[i]==hp[i]-1: ph[i] toggles and cnt[i]=0; else cnt[i]++.
  - Full period = 2*hp[i] cycles. hp=1 toggles every cycle.
  - First toggle occurs at edge k+hp.
- Sequential modes (mode_r 0/1):
  - Only channel canal_act runs; salida_audio = ph[canal_act].
  - seg increments on every PLAY edge.
  - At the edge where seg==SEG_LEN-1: seg=0; active channel's cnt and ph cleared; this takes priority over a coincident tone toggle.
    - If canal_act<N_CH-1: canal_act++.
    - Else, mode 0: state=IDLE, ocupado=0, fin=1 for one cycle, salida_audio=0.
    - Else, mode 1: canal_act=0; no fin; loop continues.
  - Channel c sounds on edges k+c*SEG_LEN+1 .. k+(c+1)*SEG_LEN.
  - canal_act changes at edge k+(c+1)*SEG_LEN.
  - One-shot fin asserts at edge k+N_CH*SEG_LEN.
- Mix mode (mode_r 2):
  - All channels run concurrently; salida_audio = XOR of all ph[i].
  - seg held at 0, canal_act=0.
  - Plays until the next bandera or rst; fin never asserts.
- IDLE: counters frozen, salida_audio=0, ocupado=0.
- Width rules: counters are W bits and compare against hp-1 with no overflow. Maximum hp = 2^W-1.
- salida_audio updates on the same edge as the phase change; no extra pipeline stage.

Test Plan:
1. N_CH=3, W=8, SEG_LEN=100. rst, then bandera with ch0=11, ch1=4, ch2=9, modo=0.
   -> salida toggles at k+11, k+22, … during segment 0; canal_act=1 at k+100 with 4-cycle half-periods; canal_act=2 at k+200; fin single pulse at k+300; ocupado=0 and salida=0 from k+300.
2. ch1=0 in the same setup -> salida_audio constant 0 from k+100 to k+200; ch0 and ch2 tones unaffected.
3. modo=1, same values -> at k+300 canal_act returns to 0, fin stays 0, ocupado stays 1; ch0 first toggle at k+311.
4. Restart: bandera at k+150 (mid ch1) with ch0=32, ch1=3 -> next edge canal_act=0, salida=0, first toggle 32 cycles after the strobe; segment timing restarts.
5. modo=2 with ch0=2, ch1=3, ch2=0 -> salida = ph0 XOR ph1, repeating with a 12-cycle period; canal_act=0; fin never asserts over 1000 cycles.
6. rst asserted at k+50 during play -> at the next edge salida, ocupado, canal_act and fin are 0, state IDLE; no activity until a new bandera.
